// File: rtl/rf_writeback_sched_if.sv
// Write-back request bundle between the execute/memory stages and the write-back scheduler.
// Each request carries up to two register writes (E and M).
interface rf_writeback_sched_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  dstE;
  logic [63:0] valE;
  logic [3:0]  dstM;
  logic [63:0] valM;

  modport master (
    output wb_valid, dstE, valE, dstM, valM,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, dstE, valE, dstM, valM,
    output wb_ready
  );
endinterface

// File: rtl/rf_writeback_sched.sv
// Y86-64 write-back scheduler: queues the E/M writes of each instruction in order and
// drains one per cycle into the single register-file write port, with RAW hazard flags and halt sequencing.
module rf_writeback_sched #(
  parameter int         DEPTH = 4,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  rf_writeback_sched_if.slave  wb,
  output logic                 rf_we,
  output logic [3:0]           rf_waddr,
  output logic [63:0]          rf_wdata,
  input  logic [3:0]           srcA,
  input  logic [3:0]           srcB,
  output logic                 hazA,
  output logic                 hazB,
  input  logic                 halt_req,
  output logic [2:0]           pending,
  output logic                 halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state, state_next;
  logic [3:0]    q_dst [DEPTH];
  logic [63:0]   q_val [DEPTH];
  logic [PW-1:0] head, tail, tail_m, off;
  logic [CW-1:0] count, free_slots;
  logic          accept, push_e, push_m, pop;
  logic [1:0]    added;

  assign free_slots  = CW'(DEPTH) - count;
  assign wb.wb_ready = (state == RUN) && (free_slots >= CW'(2));
  assign accept      = wb.wb_valid && wb.wb_ready;
  assign push_e      = accept && (wb.dstE != RNONE);
  assign push_m      = accept && (wb.dstM != RNONE);
  assign added       = {1'b0, push_e} + {1'b0, push_m};
  assign pop         = (count != '0);
  // The M entry lands behind E when both are written, so M wins on equal destinations.
  assign tail_m      = push_e ? tail + PW'(1) : tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(added);
      count <= count + CW'(added) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_e) begin
      q_dst[tail] <= wb.dstE;
      q_val[tail] <= wb.valE;
    end
    if (push_m) begin
      q_dst[tail_m] <= wb.dstM;
      q_val[tail_m] <= wb.valM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (halt_req) state_next = DRAIN;
      DRAIN:   if (count == '0) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    rf_we    = pop;
    rf_waddr = pop ? q_dst[head] : RNONE;
    rf_wdata = pop ? q_val[head] : '0;
  end

  // A slot is live when its distance from head is below count; only live slots can raise a hazard.
  always_comb begin
    hazA = 1'b0;
    hazB = 1'b0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count) begin
        if (srcA != RNONE && q_dst[i] == srcA) hazA = 1'b1;
        if (srcB != RNONE && q_dst[i] == srcB) hazB = 1'b1;
      end
    end
  end

  assign pending = 3'(count);
  assign halted  = (state == HALTED);

endmodule

// File: tb/tb_rf_writeback_sched.sv
// Randomised and directed bench for rf_writeback_sched against a queue-based behavioural model.
module tb_rf_writeback_sched;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  dst;
    logic [63:0] val;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [3:0]  srcA, srcB;
  logic        hazA, hazB;
  logic        halt_req;
  logic [2:0]  pending;
  logic        halted;

  rf_writeback_sched_if bus ();

  rf_writeback_sched #(.DEPTH(DEPTH), .RNONE(4'hF)) dut (
    .clk(clk), .reset(reset), .wb(bus),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .srcA(srcA), .srcB(srcB), .hazA(hazA), .hazB(hazB),
    .halt_req(halt_req), .pending(pending), .halted(halted)
  );

  always #5 clk = ~clk;

  // Model: queue of pending writes, mode 0=run 1=drain 2=halted; dut_rf shadows what the DUT wrote.
  wr_t         mq[$];
  int          mode;
  logic [63:0] dut_rf [16];
  int          dut_writes;
  int          checks;
  int          failures;

  logic        e_we, e_ready, e_hazA, e_hazB, e_halted;
  logic [3:0]  e_waddr;
  logic [63:0] e_wdata;
  logic [2:0]  e_pending;

  task automatic model_outputs();
    e_we      = (mq.size() != 0);
    e_waddr   = e_we ? mq[0].dst : 4'hF;
    e_wdata   = e_we ? mq[0].val : 64'd0;
    e_ready   = (mode == 0) && (DEPTH - mq.size() >= 2);
    e_pending = 3'(mq.size());
    e_halted  = (mode == 2);
    e_hazA    = 1'b0;
    e_hazB    = 1'b0;
    foreach (mq[i]) begin
      if (srcA != 4'hF && mq[i].dst == srcA) e_hazA = 1'b1;
      if (srcB != 4'hF && mq[i].dst == srcB) e_hazB = 1'b1;
    end
  endtask

  task automatic tick();
    int sz;
    bit rdy;
    sz  = mq.size();
    rdy = (mode == 0) && (DEPTH - sz >= 2);
    if (rf_we) begin
      dut_rf[rf_waddr] = rf_wdata;
      dut_writes++;
    end
    if (sz > 0) mq.delete(0);
    if (bus.wb_valid && rdy) begin
      if (bus.dstE != 4'hF) mq.push_back('{dst: bus.dstE, val: bus.valE});
      if (bus.dstM != 4'hF) mq.push_back('{dst: bus.dstM, val: bus.valM});
    end
    if (mode == 0 && halt_req) mode = 1;
    else if (mode == 1 && sz == 0) mode = 2;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
    bus.wb_valid = v;
    bus.dstE = de;
    bus.valE = ve;
    bus.dstM = dm;
    bus.valM = vm;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    halt_req = 1'b0;
    srcA = 4'hF;
    srcB = 4'hF;
    #2;
    mq.delete();
    mode = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    halt_req = 1'b0;
    srcA = 4'h2;
    srcB = 4'h3;
    #2;
    mq.delete();
    mode = 0;
    checks += 6;
    if (rf_we !== 1'b0)          begin failures++; $display("[TB] FAIL reset_we got=%0b exp=0", rf_we); end
    if (rf_waddr !== 4'hF)       begin failures++; $display("[TB] FAIL reset_waddr got=%0h exp=f", rf_waddr); end
    if (rf_wdata !== 64'd0)      begin failures++; $display("[TB] FAIL reset_wdata got=%0h exp=0", rf_wdata); end
    if (bus.wb_ready !== 1'b1)   begin failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", bus.wb_ready); end
    if (pending !== 3'd0)        begin failures++; $display("[TB] FAIL reset_pending got=%0d exp=0", pending); end
    if ({hazA, hazB, halted} !== 3'b000)
                                 begin failures++; $display("[TB] FAIL reset_haz_halt got=%b exp=000", {hazA, hazB, halted}); end
    reset = 1'b0;
    srcA = 4'hF;
    srcB = 4'hF;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    set_req(1'b1, 4'd3, 64'd99, 4'hF, 64'd0);
    tick();
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    #1;
    model_outputs();
    checks += 3;
    if (rf_we !== 1'b1 || e_we !== 1'b1) begin failures++; $display("[TB] FAIL single_we got=%0b exp=1", rf_we); end
    if (rf_waddr !== 4'd3)  begin failures++; $display("[TB] FAIL single_waddr got=%0d exp=3", rf_waddr); end
    if (rf_wdata !== 64'd99) begin failures++; $display("[TB] FAIL single_wdata got=%0d exp=99", rf_wdata); end
    tick();
    model_outputs();
    checks++;
    if (rf_we !== e_we) begin failures++; $display("[TB] FAIL single_idle got=%0b exp=%0b", rf_we, e_we); end
  endtask

  task automatic test_dual();
    set_req(1'b1, 4'd4, 64'd24, 4'd5, -64'sd7);
    tick();
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      model_outputs();
      checks += 4;
      if (pending !== e_pending) begin failures++; $display("[TB] FAIL dual_pending[%0d] got=%0d exp=%0d", k, pending, e_pending); end
      if (rf_we !== e_we)        begin failures++; $display("[TB] FAIL dual_we[%0d] got=%0b exp=%0b", k, rf_we, e_we); end
      if (rf_waddr !== e_waddr)  begin failures++; $display("[TB] FAIL dual_waddr[%0d] got=%0d exp=%0d", k, rf_waddr, e_waddr); end
      if (rf_wdata !== e_wdata)  begin failures++; $display("[TB] FAIL dual_wdata[%0d] got=%0h exp=%0h", k, rf_wdata, e_wdata); end
      tick();
    end
  endtask

  task automatic test_same_dst();
    dut_rf[4] = 64'd0;
    set_req(1'b1, 4'd4, 64'd40, 4'd4, 64'd8);
    tick();
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    #1;
    checks++;
    if (rf_wdata !== 64'd40) begin failures++; $display("[TB] FAIL same_first got=%0d exp=40", rf_wdata); end
    tick();
    tick();
    checks++;
    if (dut_rf[4] !== 64'd8) begin failures++; $display("[TB] FAIL same_final_r4 got=%0d exp=8", dut_rf[4]); end
  endtask

  task automatic test_back_to_back();
    int  idx;
    bit  saw_stall;
    bit  done;
    bit  acc;
    idx = 0;
    saw_stall = 0;
    done = 0;
    dut_writes = 0;
    for (int r = 1; r <= 6; r++) dut_rf[r] = 64'd0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      if (idx < 3) set_req(1'b1, 4'(2*idx+1), 64'(100+2*idx), 4'(2*idx+2), 64'(101+2*idx));
      else         set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
      #1;
      model_outputs();
      checks += 4;
      if (bus.wb_ready !== e_ready) begin failures++; $display("[TB] FAIL b2b_ready[%0d] got=%0b exp=%0b", cyc, bus.wb_ready, e_ready); end
      if (rf_we !== e_we)           begin failures++; $display("[TB] FAIL b2b_we[%0d] got=%0b exp=%0b", cyc, rf_we, e_we); end
      if (rf_waddr !== e_waddr)     begin failures++; $display("[TB] FAIL b2b_waddr[%0d] got=%0d exp=%0d", cyc, rf_waddr, e_waddr); end
      if (rf_wdata !== e_wdata)     begin failures++; $display("[TB] FAIL b2b_wdata[%0d] got=%0d exp=%0d", cyc, rf_wdata, e_wdata); end
      if (!e_ready && idx < 3) saw_stall = 1;
      acc = bus.wb_valid && e_ready;
      tick();
      if (acc) idx++;
      if (idx == 3 && mq.size() == 0) done = 1;
    end
    checks += 3;
    if (!done)            begin failures++; $display("[TB] FAIL b2b_timeout got=%0d exp=3 accepted", idx); end
    if (saw_stall !== 1)  begin failures++; $display("[TB] FAIL b2b_backpressure got=%0b exp=1", saw_stall); end
    if (dut_writes != 6)  begin failures++; $display("[TB] FAIL b2b_write_count got=%0d exp=6", dut_writes); end
    for (int r = 1; r <= 6; r++) begin
      checks++;
      if (dut_rf[r] !== 64'(99 + r)) begin failures++; $display("[TB] FAIL b2b_r%0d got=%0d exp=%0d", r, dut_rf[r], 99 + r); end
    end
  endtask

  task automatic test_hazard();
    set_req(1'b1, 4'd2, 64'd22, 4'd6, 64'd66);
    tick();
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    srcA = 4'd2;
    srcB = 4'hF;
    #1;
    model_outputs();
    checks += 2;
    if (hazA !== e_hazA || e_hazA !== 1'b1) begin failures++; $display("[TB] FAIL haz_a_set got=%0b exp=1", hazA); end
    if (hazB !== e_hazB) begin failures++; $display("[TB] FAIL haz_b_none got=%0b exp=%0b", hazB, e_hazB); end
    srcB = 4'd6;
    #1;
    model_outputs();
    checks++;
    if (hazB !== e_hazB) begin failures++; $display("[TB] FAIL haz_b_tail got=%0b exp=%0b", hazB, e_hazB); end
    tick();
    model_outputs();
    checks += 2;
    if (hazA !== e_hazA) begin failures++; $display("[TB] FAIL haz_a_clear got=%0b exp=%0b", hazA, e_hazA); end
    if (hazB !== e_hazB) begin failures++; $display("[TB] FAIL haz_b_held got=%0b exp=%0b", hazB, e_hazB); end
    tick();
    srcA = 4'hF;
    srcB = 4'hF;
  endtask

  task automatic test_halt();
    bit seen_halted;
    seen_halted = 0;
    set_req(1'b1, 4'd7, 64'd70, 4'd8, 64'd80);
    tick();
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen_halted; cyc++) begin
      set_req(1'b1, 4'd9, 64'd90, 4'hF, 64'd0);
      #1;
      model_outputs();
      checks += 4;
      if (bus.wb_ready !== e_ready) begin failures++; $display("[TB] FAIL halt_ready[%0d] got=%0b exp=%0b", cyc, bus.wb_ready, e_ready); end
      if (rf_we !== e_we)           begin failures++; $display("[TB] FAIL halt_we[%0d] got=%0b exp=%0b", cyc, rf_we, e_we); end
      if (pending !== e_pending)    begin failures++; $display("[TB] FAIL halt_pending[%0d] got=%0d exp=%0d", cyc, pending, e_pending); end
      if (halted !== e_halted)      begin failures++; $display("[TB] FAIL halt_flag[%0d] got=%0b exp=%0b", cyc, halted, e_halted); end
      if (halted === 1'b1) seen_halted = 1;
      else tick();
    end
    checks++;
    if (!seen_halted) begin failures++; $display("[TB] FAIL halt_timeout got=0 exp=1"); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    model_outputs();
    checks += 2;
    if (halted !== e_halted) begin failures++; $display("[TB] FAIL halt_sticky got=%0b exp=%0b", halted, e_halted); end
    if (rf_we !== e_we)      begin failures++; $display("[TB] FAIL halt_no_write got=%0b exp=%0b", rf_we, e_we); end
    do_reset();
  endtask

  task automatic test_halt_reset();
    set_req(1'b1, 4'd10, 64'd1000, 4'd11, 64'd1100);
    tick();
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    reset = 1'b1;
    #1;
    mq.delete();
    mode = 0;
    checks += 4;
    if (rf_we !== 1'b0)        begin failures++; $display("[TB] FAIL midreset_we got=%0b exp=0", rf_we); end
    if (pending !== 3'd0)      begin failures++; $display("[TB] FAIL midreset_pending got=%0d exp=0", pending); end
    if (bus.wb_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready got=%0b exp=1", bus.wb_ready); end
    if (halted !== 1'b0)       begin failures++; $display("[TB] FAIL midreset_halted got=%0b exp=0", halted); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_req(1'b1, 4'd12, 64'd1200, 4'hF, 64'd0);
    tick();
    set_req(1'b0, 4'hF, 64'd0, 4'hF, 64'd0);
    model_outputs();
    checks++;
    if (rf_waddr !== e_waddr) begin failures++; $display("[TB] FAIL midreset_resume got=%0d exp=%0d", rf_waddr, e_waddr); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] de, dm;
    for (int cyc = 0; cyc < 400; cyc++) begin
      de = 4'($urandom_range(0, 15));
      dm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) de = 4'hF;
      if ($urandom_range(0, 3) == 0) dm = 4'hF;
      set_req(1'($urandom_range(0, 1)), de, {$urandom, $urandom}, dm, {$urandom, $urandom});
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      halt_req = (cyc == 390);
      #1;
      model_outputs();
      checks += 8;
      if (rf_we !== e_we)           begin failures++; $display("[TB] FAIL rnd_we[%0d] got=%0b exp=%0b", cyc, rf_we, e_we); end
      if (rf_waddr !== e_waddr)     begin failures++; $display("[TB] FAIL rnd_waddr[%0d] got=%0d exp=%0d", cyc, rf_waddr, e_waddr); end
      if (rf_wdata !== e_wdata)     begin failures++; $display("[TB] FAIL rnd_wdata[%0d] got=%0h exp=%0h", cyc, rf_wdata, e_wdata); end
      if (bus.wb_ready !== e_ready) begin failures++; $display("[TB] FAIL rnd_ready[%0d] got=%0b exp=%0b", cyc, bus.wb_ready, e_ready); end
      if (hazA !== e_hazA)          begin failures++; $display("[TB] FAIL rnd_hazA[%0d] got=%0b exp=%0b", cyc, hazA, e_hazA); end
      if (hazB !== e_hazB)          begin failures++; $display("[TB] FAIL rnd_hazB[%0d] got=%0b exp=%0b", cyc, hazB, e_hazB); end
      if (pending !== e_pending)    begin failures++; $display("[TB] FAIL rnd_pending[%0d] got=%0d exp=%0d", cyc, pending, e_pending); end
      if (halted !== e_halted)      begin failures++; $display("[TB] FAIL rnd_halted[%0d] got=%0b exp=%0b", cyc, halted, e_halted); end
      tick();
    end
    halt_req = 1'b0;
    model_outputs();
    checks++;
    if (halted !== e_halted) begin failures++; $display("[TB] FAIL rnd_final_halted got=%0b exp=%0b", halted, e_halted); end
    do_reset();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    dut_writes = 0;
    mode = 0;
    for (int r = 0; r < 16; r++) dut_rf[r] = 64'd0;
    test_reset();
    test_single();
    test_dual();
    test_same_dst();
    test_back_to_back();
    test_hazard();
    test_halt();
    test_halt_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
